// File: rtl/hazard_unit_pkg.sv
// Shared constants for the ID-stage hazard unit: stage indices,
// pause/ALU codes and the in-flight scoreboard entry layout.
package hazard_unit_pkg;

    localparam int STG_EXE = 0;
    localparam int STG_MEM = 1;
    localparam int STG_WB  = 2;

    localparam int MAX_RADDR_W = 8;
    localparam int MAX_DEPTH   = 6;

    typedef enum logic [1:0] {
        PAUSE_NONE,
        PAUSE_STALL,
        PAUSE_FLUSH
    } pause_e;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_SLT,
        ALU_SLTU
    } alu_op_e;

    // ready = first stage index whose stage_data carries the result
    typedef struct packed {
        logic                   valid;
        logic                   we;
        logic [MAX_RADDR_W-1:0] waddr;
        logic [2:0]             ready;
    } sb_entry_t;

    function automatic int fwd_sel_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int FWD_SEL_W = fwd_sel_w(3);

endpackage

// File: rtl/hazard_unit_if.sv
// ID-stage <-> hazard unit bundle: operand requests in,
// stall / forwarded operands out.
interface hazard_unit_if #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5,
    parameter int DEPTH   = 3
);
    localparam int SEL_W = hazard_unit_pkg::fwd_sel_w(DEPTH);

    logic                    id_valid;
    logic [RADDR_W-1:0]      id_rs;
    logic [RADDR_W-1:0]      id_rt;
    logic                    id_rs_used;
    logic                    id_rt_used;
    logic                    id_we;
    logic [RADDR_W-1:0]      id_waddr;
    logic                    id_is_load;
    logic [XLEN-1:0]         rs_rf_data;
    logic [XLEN-1:0]         rt_rf_data;
    logic [DEPTH*XLEN-1:0]   stage_data;
    logic                    flush;

    logic                    stall;
    logic [XLEN-1:0]         rs_data;
    logic [XLEN-1:0]         rt_data;
    logic [SEL_W-1:0]        rs_fwd_sel;
    logic [SEL_W-1:0]        rt_fwd_sel;
    logic [31:0]             stall_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
        output id_we, id_waddr, id_is_load,
        output rs_rf_data, rt_rf_data, stage_data, flush,
        input  stall, rs_data, rt_data,
        input  rs_fwd_sel, rt_fwd_sel, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
        input  id_we, id_waddr, id_is_load,
        input  rs_rf_data, rt_rf_data, stage_data, flush,
        output stall, rs_data, rt_data,
        output rs_fwd_sel, rt_fwd_sel, stall_cnt
    );

endinterface

// File: rtl/hazard_unit_fwd_select.sv
// Per-operand youngest-match search over the scoreboard and
// operand mux; flags a hazard when the match is not yet forwardable.
module fwd_select
    import hazard_unit_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5,
    parameter int DEPTH   = 3,
    parameter int SEL_W   = 2
) (
    input  logic                  used,
    input  logic [RADDR_W-1:0]    addr,
    input  logic [XLEN-1:0]       rf_data,
    input  sb_entry_t [DEPTH-1:0] sb,
    input  logic [DEPTH*XLEN-1:0] stage_data,
    output logic [XLEN-1:0]       data,
    output logic [SEL_W-1:0]      sel,
    output logic                  hazard
);

    logic [MAX_RADDR_W-1:0] addr_x;
    logic                   addr_nz;
    logic [DEPTH-1:0]       hit;

    assign addr_x  = MAX_RADDR_W'(addr);
    assign addr_nz = (addr != '0);

    always_comb begin
        hit = '0;
        for (int k = 0; k < DEPTH; k++) begin
            hit[k] = used && addr_nz && sb[k].valid && sb[k].we
                  && (sb[k].waddr == addr_x);
        end
    end

    // oldest first so the youngest hit overwrites
    always_comb begin
        data   = rf_data;
        sel    = '0;
        hazard = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (hit[k]) begin
                if (k < int'(sb[k].ready)) begin
                    hazard = 1'b1;
                    data   = rf_data;
                    sel    = '0;
                end else begin
                    hazard = 1'b0;
                    data   = stage_data[k*XLEN +: XLEN];
                    sel    = SEL_W'(k + 1);
                end
            end
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// ID-stage hazard unit: tracks in-flight writers, forwards
// operands and stalls on not-yet-ready load results.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int RADDR_W    = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_READY = 1
) (
    input  logic          clk,
    input  logic          rst,
    hazard_unit_if.slave  hu
);

    localparam int SEL_W = fwd_sel_w(DEPTH);

    sb_entry_t [DEPTH-1:0] sb_q;
    sb_entry_t             entry_in;
    logic                  rs_hazard;
    logic                  rt_hazard;
    logic                  stall;
    pause_e                pause;
    logic [31:0]           cnt_q;

    fwd_select #(
        .XLEN    (XLEN),
        .RADDR_W (RADDR_W),
        .DEPTH   (DEPTH),
        .SEL_W   (SEL_W)
    ) u_rs (
        .used       (hu.id_rs_used),
        .addr       (hu.id_rs),
        .rf_data    (hu.rs_rf_data),
        .sb         (sb_q),
        .stage_data (hu.stage_data),
        .data       (hu.rs_data),
        .sel        (hu.rs_fwd_sel),
        .hazard     (rs_hazard)
    );

    fwd_select #(
        .XLEN    (XLEN),
        .RADDR_W (RADDR_W),
        .DEPTH   (DEPTH),
        .SEL_W   (SEL_W)
    ) u_rt (
        .used       (hu.id_rt_used),
        .addr       (hu.id_rt),
        .rf_data    (hu.rt_rf_data),
        .sb         (sb_q),
        .stage_data (hu.stage_data),
        .data       (hu.rt_data),
        .sel        (hu.rt_fwd_sel),
        .hazard     (rt_hazard)
    );

    // a redirect kills ID outright, so it overrides any stall
    always_comb begin
        pause = PAUSE_NONE;
        unique case (1'b1)
            hu.flush:
                pause = PAUSE_FLUSH;
            !hu.flush && hu.id_valid && (rs_hazard || rt_hazard):
                pause = PAUSE_STALL;
            default:
                pause = PAUSE_NONE;
        endcase
    end

    assign stall = (pause == PAUSE_STALL);

    always_comb begin
        entry_in = '0;
        if (pause == PAUSE_NONE && hu.id_valid) begin
            entry_in.valid = 1'b1;
            entry_in.we    = hu.id_we;
            entry_in.waddr = MAX_RADDR_W'(hu.id_waddr);
            entry_in.ready = hu.id_is_load ? 3'(LOAD_READY) : 3'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_q  <= '0;
            cnt_q <= '0;
        end else begin
            sb_q <= {sb_q[DEPTH-2:0], entry_in};
            if (stall && cnt_q != 32'hFFFF_FFFF) begin
                cnt_q <= cnt_q + 32'd1;
            end
        end
    end

    assign hu.stall     = stall;
    assign hu.stall_cnt = cnt_q;

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath width.
REQ-002 SHALL have parameter RADDR_W, default 5, meaning register-address width.
REQ-003 SHALL have parameter DEPTH, default 3, meaning tracked stages after ID (0=EXE, 1=MEM, 2=WB); legal range 2..6.
REQ-004 SHALL have parameter LOAD_READY, default 1, meaning the first stage index at which load data is forwardable; must be less than DEPTH.
REQ-005 SHALL have one clock and a synchronous, active-high reset, with ports clk and rst.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 id_valid  input  1  ID holds a real instruction.
REQ-009 id_rs, id_rt  input  RADDR_W each  source register addresses.
REQ-010 id_rs_used, id_rt_used  input  1 each  source operand is read.
REQ-011 id_we, id_waddr, id_is_load  input  1/RADDR_W/1  destination write enable, address, load flag.
REQ-012 rs_rf_data, rt_rf_data  input  XLEN each  register-file read data.
REQ-013 stage_data  input  DEPTH*XLEN  result of stage k in slice k.
REQ-014 flush  input  1  branch/jump redirect; kills the instruction in ID.
REQ-015 stall  output  1  hold PC and IF_ID and insert a bubble into EXE.
REQ-016 rs_data, rt_data  output  XLEN each  forwarded operands.
REQ-017 rs_fwd_sel, rt_fwd_sel  output  $clog2(DEPTH+1) each  0 = regfile, k+1 = stage k.
REQ-018 stall_cnt  output  32  saturating count of stall cycles.

Function
REQ-019 SHALL keep a DEPTH-entry scoreboard; each entry holds {valid, we, waddr, ready}, where ready = LOAD_READY for loads and 0 otherwise.
REQ-020 Every cycle, entry k SHALL shift to entry k+1, and entry DEPTH-1 SHALL be discarded; the scoreboard never pauses.
REQ-021 Entry 0 SHALL load the ID instruction when id_valid & ~stall & ~flush; otherwise it SHALL load a bubble with valid=0.
REQ-022 An operand SHALL match entry k when used, valid, we, waddr==addr, and addr!=0.
REQ-023 Register 0 SHALL never match, forward, or stall; its data comes from the regfile.
REQ-024 When several entries match, the lowest k (youngest) SHALL win.
REQ-025 If the winning entry has k >= ready, the operand SHALL select stage_data slice k and sel SHALL be k+1; if no entry matches, sel SHALL be 0 and data SHALL be the regfile value.
REQ-026 If the winning entry has k < ready, stall SHALL be 1; stall = id_valid & ~flush & (rs_hazard | rt_hazard).
REQ-027 stall, sel and data SHALL be combinational in the current inputs and scoreboard, with 0 cycles latency.
REQ-028 Load-use with the default parameters SHALL give exactly 1 stall cycle; a dependent instruction two behind the load SHALL give 0.
REQ-029 flush and a hazard in the same cycle: flush SHALL win, stall SHALL be 0, and a bubble SHALL enter.
REQ-030 stall_cnt SHALL increment on each cycle with stall=1 and saturate at 32'hFFFF_FFFF.

Reset
REQ-031 On rst, all scoreboard valid bits SHALL be 0 and stall_cnt SHALL be 0 by the next edge.
REQ-032 Outputs after reset SHALL be stall=0 and sel=0, with data equal to the regfile inputs.
REQ-033 rst asserted mid-stall SHALL discard all pending hazards; the first post-reset instruction SHALL issue without stalling.

Structure
REQ-034 FWD_SEL width, stage indices (STG_EXE, STG_MEM, STG_WB) and the scoreboard entry type SHALL live in the shared constants include alongside the existing PAUSE/ALU definitions.
REQ-035 One sub-module, fwd_select, SHALL perform the per-operand youngest-match search and mux, and SHALL be instantiated twice (rs, rt).

Verification
REQ-036 Scenario: ADD r3 then ADD r4,r3,r3 back-to-back with stage0 data 0x11 -> rs_fwd_sel=1, rt_fwd_sel=1, rs_data=0x11, stall=0.
REQ-037 Scenario: LW r5 then ADD r6,r5,r0 -> stall=1 for exactly 1 cycle, then rs_fwd_sel=2 with MEM data 0xDEAD_BEEF, stall_cnt=1.
REQ-038 Scenario: writes to r7 in EXE (0x2) and WB (0x9), ID reads r7 -> EXE wins, rs_data=0x2, sel=1.
REQ-039 Scenario: entry writes r0 with data 0x55, ID reads r0 with rf data 0 -> sel=0, data=0, stall=0.
REQ-040 Scenario: load-use hazard with flush=1 in the same cycle -> stall=0, and entry 0 becomes a bubble on the next cycle.
REQ-041 Scenario: DEPTH=4, LOAD_READY=2, LW then dependent instruction -> 2 stall cycles, then sel=3; rst mid-stall -> stall=0 on the next cycle and stall_cnt=0.
